// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA operand path.
// Contents: region select codes, words per operand region, fixed region bases,
// the operand-fetch state type, and a helper that maps a region code to its
// base word address.
package rsa_pkg;

  localparam logic [1:0] REGION_B    = 2'd0;
  localparam logic [1:0] REGION_KEY  = 2'd1;
  localparam logic [1:0] REGION_N    = 2'd2;
  localparam logic [1:0] REGION_RSVD = 2'd3;

  localparam int unsigned RSA_WORDS = 64;

  localparam int unsigned BASE_B   = 0 * RSA_WORDS;
  localparam int unsigned BASE_KEY = 1 * RSA_WORDS;
  localparam int unsigned BASE_N   = 2 * RSA_WORDS;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } fetch_state_t;

  // Region bases are contiguous, so the base is simply region * words.
  function automatic int unsigned region_base(input logic [1:0] region,
                                              input int unsigned words);
    return int'(region) * words;
  endfunction

endpackage

// File: rtl/rsa_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports:
//   clk, rst  clock and synchronous active-high reset (flushes the FIFO)
//   i_push    write i_data this cycle
//   i_data    entry to write (W bits)
//   i_pop     remove the head entry this cycle (ignored when empty)
//   o_data    head entry, valid while o_empty is low
//   o_empty   no entries stored
//   o_count   number of stored entries, 0..DEPTH
// Push and pop in the same cycle are allowed even when full; the caller must
// never push into a full FIFO without popping.
module rsa_sync_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 39,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  output logic [W-1:0]  o_data,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [PW-1:0] w_wptr_nxt;
  logic [PW-1:0] w_rptr_nxt;
  logic          w_pop;

  assign o_empty = (r_count == '0);
  assign w_pop   = i_pop & ~o_empty;

  // Explicit wrap so non-power-of-two depths work.
  always_comb begin
    w_wptr_nxt = (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + PW'(1);
    w_rptr_nxt = (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_wptr <= w_wptr_nxt;
      end
      if (w_pop) begin
        r_rptr <= w_rptr_nxt;
      end
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/rsa_operand_fetch.sv
// Operand fetch: reads one WORDS-long region of the input SRAM and streams it
// out as a valid/ready word stream tagged with index and last flag.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start, region        begin fetch of region (0=B, 1=key, 2=N, 3=rejected)
//   busy, done, err      status; done pulses once per fetch, err marks region 3
//   sram_en, sram_addr   SRAM read request (1-cycle registered-address read)
//   sram_data            SRAM read data, valid the cycle after the enable edge
//   out_valid/out_ready  stream handshake
//   out_data/idx/last    stream word, its index in the region, last-word flag
module rsa_operand_fetch
  import rsa_pkg::*;
#(
  parameter int unsigned WORDS = RSA_WORDS,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 8,
  parameter int unsigned DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    region,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          sram_en,
  output logic [AW-1:0] sram_addr,
  input  logic [DW-1:0] sram_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [5:0]    out_idx,
  output logic          out_last
);

  localparam int unsigned EW = DW + 6 + 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned RW = $clog2(WORDS + 1);

  fetch_state_t  r_state;
  fetch_state_t  w_state_nxt;
  logic [AW-1:0] r_base;
  logic [RW-1:0] r_rd_cnt;
  logic          r_pending;
  logic [5:0]    r_pend_idx;
  logic          r_done;
  logic          r_err;

  logic          w_accept;
  logic          w_reject;
  logic          w_issue;
  logic          w_pop;
  logic          w_empty;
  logic          w_credit_ok;
  logic          w_last_xfer;
  logic [CW-1:0] w_cnt;
  logic [EW-1:0] w_push_data;
  logic [EW-1:0] w_head;

  assign w_accept = (r_state == IDLE) && start && (region != REGION_RSVD);
  assign w_reject = (r_state == IDLE) && start && (region == REGION_RSVD);

  assign w_pop = ~w_empty & out_ready;

  // Credit: words already buffered plus the one in flight from the SRAM,
  // less the word leaving this cycle, must leave room for another read.
  assign w_credit_ok = (32'(w_cnt) + 32'(r_pending) - 32'(w_pop)) < DEPTH;
  assign w_issue     = (r_state == FETCH) && (r_rd_cnt < RW'(WORDS)) && w_credit_ok;

  assign w_last_xfer = w_pop && out_last;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = FETCH;
      FETCH:   if (w_issue && (r_rd_cnt == RW'(WORDS - 1))) w_state_nxt = DRAIN;
      DRAIN:   if (w_last_xfer) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_base     <= '0;
      r_rd_cnt   <= '0;
      r_pending  <= 1'b0;
      r_pend_idx <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done     <= w_reject || ((r_state == DRAIN) && w_last_xfer);
      r_err      <= w_reject;
      r_pending  <= w_issue;
      r_pend_idx <= 6'(r_rd_cnt);
      if (w_accept) begin
        r_base   <= AW'(region_base(region, WORDS));
        r_rd_cnt <= '0;
      end else if (w_issue) begin
        r_rd_cnt <= r_rd_cnt + RW'(1);
      end
    end
  end

  assign w_push_data = {(r_pend_idx == 6'(WORDS - 1)), r_pend_idx, sram_data};

  rsa_sync_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_pending),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_count (w_cnt)
  );

  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign err       = r_err;
  assign sram_en   = w_issue;
  assign sram_addr = w_issue ? (r_base + AW'(r_rd_cnt)) : '0;

  // Stale FIFO storage is masked so an empty FIFO presents zeros.
  assign out_valid = ~w_empty;
  assign out_data  = out_valid ? w_head[DW-1:0] : '0;
  assign out_idx   = out_valid ? w_head[DW+5:DW] : '0;
  assign out_last  = out_valid & w_head[DW+6];

endmodule

// File: tb/tb_rsa_operand_fetch.sv
module tb_rsa_operand_fetch;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  region = 2'd0;
  logic        busy, done, err, sram_en;
  logic [7:0]  sram_addr;
  logic [31:0] sram_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [5:0]  out_idx;
  logic        out_last;

  int total = 0;
  int bad = 0;
  int g_base, exp_k, issued, outstanding, dones, cyc, first_c, done_c, busy_seen;
  logic done_err;
  logic poked;

  rsa_operand_fetch #(
    .WORDS (64),
    .DEPTH (DEPTH),
    .AW    (8),
    .DW    (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .region    (region),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .sram_en   (sram_en),
    .sram_addr (sram_addr),
    .sram_data (sram_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ramv(input int a);
    return 32'(a) * 32'h01010101;
  endfunction

  // SRAM with fixed content, 1-cycle registered-address read.
  always @(posedge clk) begin
    if (sram_en) sram_data <= ramv(int'(sram_addr));
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counters(input int base);
    g_base = base; exp_k = 0; issued = 0; outstanding = 0; dones = 0;
    cyc = 0; first_c = -1; done_c = -1; busy_seen = 0; done_err = 1'b0;
  endtask

  // One cycle: sample just after the negedge (inputs already applied), check, advance.
  task automatic step();
    logic xfer;
    #1;
    xfer = out_valid && out_ready;
    if (sram_en) begin
      check("credit", 64'((outstanding - (xfer ? 1 : 0)) < DEPTH), 64'd1);
      check("addr", 64'(sram_addr), 64'(g_base + issued));
    end
    if (busy) busy_seen = 1;
    if (out_valid && first_c < 0) first_c = cyc;
    if (xfer) begin
      check("data", 64'(out_data), 64'(ramv(g_base + exp_k)));
      check("idx", 64'(out_idx), 64'(exp_k));
      check("last", 64'(out_last), 64'(exp_k == 63));
      exp_k++;
    end
    if (done) begin
      dones++;
      if (done_c < 0) begin
        done_c = cyc;
        done_err = err;
      end
    end
    if (sram_en) issued++;
    outstanding += (sram_en ? 1 : 0) - (xfer ? 1 : 0);
    cyc++;
    @(negedge clk);
  endtask

  task automatic begin_fetch(input int r);
    clear_counters(r * 64);
    region = 2'(r);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string p);
    check({p, "_busy"}, 64'(busy), 64'd0);
    check({p, "_done"}, 64'(done), 64'd0);
    check({p, "_err"}, 64'(err), 64'd0);
    check({p, "_sram_en"}, 64'(sram_en), 64'd0);
    check({p, "_sram_addr"}, 64'(sram_addr), 64'd0);
    check({p, "_out_valid"}, 64'(out_valid), 64'd0);
    check({p, "_out_data"}, 64'(out_data), 64'd0);
    check({p, "_out_idx"}, 64'(out_idx), 64'd0);
    check({p, "_out_last"}, 64'(out_last), 64'd0);
  endtask

  initial begin
    // Reset
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("rst0");
    @(negedge clk);

    // 1: region 1, ready held high
    out_ready = 1'b1;
    begin_fetch(1);
    while (dones == 0 && cyc < 200) step();
    check("t1_first_cycle", 64'(first_c), 64'd3);
    check("t1_done_cycle", 64'(done_c), 64'd67);
    check("t1_words", 64'(exp_k), 64'd64);
    check("t1_err", 64'(done_err), 64'd0);
    #1;
    check("t1_done_pulse", 64'(done), 64'd0);
    check("t1_busy_after", 64'(busy), 64'd0);
    @(negedge clk);

    // 2: region 2, random backpressure
    begin_fetch(2);
    while (dones == 0 && cyc < 800) begin
      out_ready = 1'($urandom_range(0, 1));
      step();
    end
    out_ready = 1'b1;
    repeat (3) step();
    check("t2_words", 64'(exp_k), 64'd64);
    check("t2_dones", 64'(dones), 64'd1);
    check("t2_issued", 64'(issued), 64'd64);

    // 3: reserved region rejected
    begin_fetch(3);
    #1;
    check("t3_done", 64'(done), 64'd1);
    check("t3_err", 64'(err), 64'd1);
    check("t3_busy", 64'(busy), 64'd0);
    repeat (5) step();
    check("t3_no_reads", 64'(issued), 64'd0);
    check("t3_busy_seen", 64'(busy_seen), 64'd0);
    check("t3_dones", 64'(dones), 64'd1);
    check("t3_done_cycle", 64'(done_c), 64'd1);

    // 4: start with region 2 during a region 0 fetch is ignored
    begin_fetch(0);
    poked = 1'b0;
    while (dones == 0 && cyc < 300) begin
      if (exp_k == 10 && !poked) begin
        start = 1'b1;
        region = 2'd2;
        poked = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    repeat (3) step();
    check("t4_words", 64'(exp_k), 64'd64);
    check("t4_dones", 64'(dones), 64'd1);
    check("t4_poked", 64'(poked), 64'd1);

    // 5: reset at word 20 aborts, then a clean refetch
    begin_fetch(0);
    while (exp_k < 20 && cyc < 200) step();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("t5");
    @(negedge clk);
    clear_counters(0);
    repeat (4) step();
    check("t5_no_reads", 64'(issued), 64'd0);
    check("t5_no_done", 64'(dones), 64'd0);
    begin_fetch(0);
    while (dones == 0 && cyc < 200) step();
    check("t5_words", 64'(exp_k), 64'd64);
    check("t5_dones", 64'(dones), 64'd1);

    // 6: stall for 10 cycles at word 5
    begin_fetch(0);
    while (exp_k < 5 && cyc < 200) step();
    repeat (10) begin
      out_ready = 1'b0;
      #1;
      check("t6_valid", 64'(out_valid), 64'd1);
      check("t6_hold_data", 64'(out_data), 64'(ramv(5)));
      check("t6_hold_idx", 64'(out_idx), 64'd5);
      check("t6_outstanding", 64'(outstanding <= DEPTH), 64'd1);
      step();
    end
    out_ready = 1'b1;
    while (dones == 0 && cyc < 300) step();
    check("t6_words", 64'(exp_k), 64'd64);
    check("t6_dones", 64'(dones), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
